logic_arb: RTL

LOGIC_ARB -- requirements
Module: logic_arb

---
 rtl/logic_arb.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/logic_arb.sv
// logic_arb -- four-requester round-robin arbiter in front of a shared bitwise ALU.
//
// A requester is granted only while the arbiter is idle. The grant starts with the
// first set REQ bit at or after the round-robin pointer, searching upward and
// wrapping from 3 to 0. The winner's opcode and operands are captured when it is
// granted. The result is computed one cycle later and then held until it is
// acknowledged.
//
// Ports
//   CLK    in   clock; all state changes on the rising edge
//   RST    in   synchronous active-high reset
//   REQ    in   [3:0]         per-requester request
//   OP     in   [7:0]         per-requester opcode, bits [2i+1:2i]
//                             00 AND, 01 OR, 10 XOR, 11 NAND
//   X, Y   in   [4*WIDTH-1:0] per-requester operands, slice i = [WIDTH*i +: WIDTH]
//   GNT    out  [3:0]         one-hot grant pulse, one cycle wide
//   OUT    out  [WIDTH-1:0]   registered result
//   VALID  out                OUT/ID hold a result
//   ID     out  [1:0]         requester that owns OUT
//   ACK    in                 consumer accepts the result (sampled only in DONE)
module logic_arb #(
   parameter int WIDTH = 8
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic [3:0]         REQ,
   input  logic [7:0]         OP,
   input  logic [4*WIDTH-1:0] X,
   input  logic [4*WIDTH-1:0] Y,
   output logic [3:0]         GNT,
   output logic [WIDTH-1:0]   OUT,
   output logic               VALID,
   output logic [1:0]         ID,
   input  logic               ACK
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic [1:0]       ptr, ptr_nxt;
   logic [1:0]       cap_id, cap_id_nxt;
   logic [1:0]       cap_op, cap_op_nxt;
   logic [WIDTH-1:0] cap_x, cap_x_nxt;
   logic [WIDTH-1:0] cap_y, cap_y_nxt;
   logic [3:0]       gnt_nxt;
   logic [WIDTH-1:0] out_nxt;
   logic             valid_nxt;
   logic [1:0]       id_nxt;

   logic             win_found;
   logic [1:0]       win_id;
   logic [1:0]       idx;

   function automatic logic [WIDTH-1:0] alu(input logic [1:0] op,
                                            input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b);
      case (op)
         2'b00:   alu = a & b;
         2'b01:   alu = a | b;
         2'b10:   alu = a ^ b;
         default: alu = ~(a & b);
      endcase
   endfunction

   // Round-robin search: the first request at or after ptr wins. The 2-bit sum wraps naturally.
   always_comb begin
      win_found = 1'b0;
      win_id    = ptr;
      idx       = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         idx = ptr + 2'(i);
         if (!win_found && REQ[idx]) begin
            win_found = 1'b1;
            win_id    = idx;
         end
      end
   end

   always_comb begin
      state_nxt  = state;
      ptr_nxt    = ptr;
      cap_id_nxt = cap_id;
      cap_op_nxt = cap_op;
      cap_x_nxt  = cap_x;
      cap_y_nxt  = cap_y;
      gnt_nxt    = '0;
      out_nxt    = OUT;
      valid_nxt  = VALID;
      id_nxt     = ID;

      case (state)
         IDLE: begin
            if (win_found) begin
               gnt_nxt    = 4'b0001 << win_id;
               cap_id_nxt = win_id;
               cap_op_nxt = OP[2*win_id +: 2];
               cap_x_nxt  = X[WIDTH*win_id +: WIDTH];
               cap_y_nxt  = Y[WIDTH*win_id +: WIDTH];
               state_nxt  = EXEC;
            end
         end
         EXEC: begin
            out_nxt   = alu(cap_op, cap_x, cap_y);
            valid_nxt = 1'b1;
            id_nxt    = cap_id;
            state_nxt = DONE;
         end
         DONE: begin
            if (ACK) begin
               valid_nxt = 1'b0;
               ptr_nxt   = cap_id + 2'd1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state  <= IDLE;
         ptr    <= '0;
         cap_id <= '0;
         cap_op <= '0;
         cap_x  <= '0;
         cap_y  <= '0;
         GNT    <= '0;
         OUT    <= '0;
         VALID  <= 1'b0;
         ID     <= '0;
      end else begin
         state  <= state_nxt;
         ptr    <= ptr_nxt;
         cap_id <= cap_id_nxt;
         cap_op <= cap_op_nxt;
         cap_x  <= cap_x_nxt;
         cap_y  <= cap_y_nxt;
         GNT    <= gnt_nxt;
         OUT    <= out_nxt;
         VALID  <= valid_nxt;
         ID     <= id_nxt;
      end
   end

endmodule
